// File: rtl/adder_pkg.sv
// Shared definitions for the time-multiplexed adder controllers:
// sequencer state type, default data width and float16 bench constants.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DONE    = 2'd3
  } adder_seq_state_t;

  localparam int ADDER_BITS_DEFAULT = 16;

  // float16 encodings of 1.0 and +0.0
  localparam logic [15:0] FP16_ONE  = 16'h3C00;
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Operand counter advance; the counter is 8 bits wide to cover up to 255 operands.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt);
    return cnt + 8'd1;
  endfunction

endpackage

// File: rtl/adder_wdog.sv
// Watchdog for an external adder: counts enabled cycles, clears on demand
// and pulses timeout_o during the TIMEOUT-th consecutive enabled cycle.
module adder_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // A clear in the same cycle (result arrived) suppresses the timeout.
  assign timeout_o = en_i && !clr_i && (count_q == LAST);

  // Next count: clear has priority, otherwise count while enabled, saturating at LAST.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/adder_seq_ctrl.sv
// Reduction sequencer: sums NUM operands per frame through one shared,
// externally instantiated 2-input adder, one add in flight at a time.
module adder_seq_ctrl
  import adder_pkg::*;
#(
  parameter int BITS    = ADDER_BITS_DEFAULT,
  parameter int NUM     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            add_valid,
  output logic [BITS-1:0] add_i0,
  output logic [BITS-1:0] add_i1,
  input  logic [BITS-1:0] add_o,
  input  logic            add_valid_out,
  output logic            busy,
  output logic            err,
  input  logic            err_clr
);

  localparam logic [7:0] NUM_C = 8'(NUM);

  adder_seq_state_t state_q, state_d;
  logic [BITS-1:0]  acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             add_valid_q, add_valid_d;
  logic [BITS-1:0]  add_i0_q, add_i0_d;
  logic [BITS-1:0]  add_i1_q, add_i1_d;
  logic             err_q, err_d;
  logic             err_set;
  logic             in_hs;
  logic             out_hs;
  logic             wdog_en;
  logic             wdog_clr;
  logic             wdog_to;

  // Handshakes are decoded purely from state, so in_ready is valid even in reset.
  assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_COLLECT);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = acc_q;
  assign add_valid = add_valid_q;
  assign add_i0    = add_i0_q;
  assign add_i1    = add_i1_q;
  assign err       = err_q;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // The watchdog only runs while an add is outstanding; leaving WAIT or a result resets it.
  assign wdog_en  = (state_q == ST_WAIT);
  assign wdog_clr = (state_q != ST_WAIT) || add_valid_out;

  adder_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (resetn),
    .en_i      (wdog_en),
    .clr_i     (wdog_clr),
    .timeout_o (wdog_to)
  );

  // Next-state, datapath and error-set decode; add_valid is a one-cycle issue pulse.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    add_valid_d = 1'b0;
    add_i0_d    = add_i0_q;
    add_i1_d    = add_i1_q;
    err_set     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (add_valid_out) begin
          err_set = 1'b1;
        end
        if (in_hs) begin
          acc_d   = in_data;
          cnt_d   = 8'd1;
          state_d = (NUM == 1) ? ST_DONE : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        if (add_valid_out) begin
          err_set = 1'b1;
        end
        if (in_hs) begin
          add_i0_d    = acc_q;
          add_i1_d    = in_data;
          add_valid_d = 1'b1;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // A result in the timeout cycle still counts; the watchdog is cleared by it.
        if (add_valid_out) begin
          acc_d   = add_o;
          cnt_d   = cnt_next(cnt_q);
          state_d = (cnt_next(cnt_q) == NUM_C) ? ST_DONE : ST_COLLECT;
        end else if (wdog_to) begin
          err_set = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      ST_DONE: begin
        if (add_valid_out) begin
          err_set = 1'b1;
        end
        if (out_hs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky error: a set event beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Control and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      add_valid_q <= 1'b0;
      add_i0_q    <= '0;
      add_i1_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      add_valid_q <= add_valid_d;
      add_i0_q    <= add_i0_d;
      add_i1_q    <= add_i1_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: a NUM=4/TIMEOUT=8 instance driven through a
// 2-cycle adder model (float16 or plain 16-bit add), plus a NUM=1 instance.
`timescale 1ns/1ps
module tb_adder_seq_ctrl;
  import adder_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_data, out_data;
  logic        add_valid, add_valid_out, busy, err, err_clr;
  logic [15:0] add_i0, add_i1, add_o;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0] b_in_data, b_out_data;
  logic        b_add_valid, b_add_valid_out, b_busy, b_err, b_err_clr;
  logic [15:0] b_add_i0, b_add_i1, b_add_o;

  logic        fmode, hang, spur;
  logic [15:0] spur_data;
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [15:0] d1_r = '0, d2_r = '0;
  logic        prev_av = 1'b0;
  int          viol = 0;
  int          b_pulses = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  adder_seq_ctrl #(.BITS(16), .NUM(4), .TIMEOUT(8)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .add_valid(add_valid), .add_i0(add_i0), .add_i1(add_i1),
    .add_o(add_o), .add_valid_out(add_valid_out),
    .busy(busy), .err(err), .err_clr(err_clr)
  );

  adder_seq_ctrl #(.BITS(16), .NUM(1), .TIMEOUT(8)) dut1 (
    .clk(clk), .resetn(resetn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .add_valid(b_add_valid), .add_i0(b_add_i0), .add_i1(b_add_i1),
    .add_o(b_add_o), .add_valid_out(b_add_valid_out),
    .busy(b_busy), .err(b_err), .err_clr(b_err_clr)
  );

  // float16 add for positive normal operands (exact for the directed values used)
  function automatic logic [15:0] fp16_add_pos(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    logic [4:0]  ea, eb, e;
    logic [11:0] ma, mb, s;
    if (b[14:10] > a[14:10]) begin t = a; a = b; b = t; end
    ea = a[14:10];
    eb = b[14:10];
    ma = {2'b01, a[9:0]};
    mb = {2'b01, b[9:0]} >> (ea - eb);
    s  = ma + mb;
    e  = ea;
    if (s[11]) begin s = s >> 1; e = e + 5'd1; end
    return {1'b0, e, s[9:0]};
  endfunction

  // Two-cycle adder model; not reset, so an issued add survives a controller reset.
  always @(posedge clk) begin
    d1_v <= add_valid;
    d1_r <= fmode ? fp16_add_pos(add_i0, add_i1) : (add_i0 + add_i1);
    d2_v <= d1_v && !hang;
    d2_r <= d1_r;
  end
  assign add_valid_out = d2_v || spur;
  assign add_o         = spur ? spur_data : d2_r;

  // Protocol monitor: back-to-back issue strobes and any issue from the NUM=1 instance.
  always @(posedge clk) begin
    prev_av <= add_valid;
    if (add_valid && prev_av) viol <= viol + 1;
    if (b_add_valid) b_pulses <= b_pulses + 1;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Streams four operands with in_valid held; returns in the first out_valid cycle.
  task automatic send_frame(input logic [15:0] op0, input logic [15:0] op1,
                            input logic [15:0] op2, input logic [15:0] op3,
                            output logic [15:0] sum, output int lat, output int pulses);
    logic [15:0] ops[4];
    int idx, c, acc_c;
    bit hs;
    ops[0] = op0; ops[1] = op1; ops[2] = op2; ops[3] = op3;
    idx = 0; c = 0; acc_c = 0; lat = -1; pulses = 0; sum = '0;
    in_valid = 1'b1;
    in_data  = ops[0];
    while (c < 300) begin
      hs = in_valid && in_ready;
      if (add_valid) pulses++;
      if (out_valid) begin
        lat = c - acc_c;
        sum = out_data;
        break;
      end
      tick();
      c++;
      if (hs) begin
        if (idx == 0) acc_c = c - 1;
        idx++;
        if (idx < 4) in_data = ops[idx];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  logic [15:0] sum, exp_sum, saved;
  logic [15:0] r[4];
  int lat, pulses, n, w;
  bit saw;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; err_clr = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_err_clr = 1'b0;
    b_add_o = '0; b_add_valid_out = 1'b0;
    fmode = 1'b1; hang = 1'b0; spur = 1'b0; spur_data = '0;

    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_add_valid", add_valid, 0);
    chk("rst_add_i0", add_i0, 0);
    chk("rst_add_i1", add_i1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();

    // 1+2+3+4 in float16, then five cycles of output backpressure
    send_frame(FP16_ONE, 16'h4000, 16'h4200, 16'h4400, sum, lat, pulses);
    chk("fp_latency", lat, 13);
    chk("fp_sum", sum, 16'h4900);
    chk("fp_pulses", pulses, 3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 16'h4900);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    release_out();
    chk("bp_release_busy", busy, 0);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    // 1+1+1+1 = 4.0
    send_frame(FP16_ONE, FP16_ONE, FP16_ONE, FP16_ONE, sum, lat, pulses);
    chk("fp_sum2", sum, 16'h4400);
    release_out();

    // random 16-bit frames with random output stall
    fmode = 1'b0;
    for (int f = 0; f < 6; f++) begin
      exp_sum = '0;
      for (int k = 0; k < 4; k++) begin
        r[k] = 16'($urandom);
        exp_sum = exp_sum + r[k];
      end
      send_frame(r[0], r[1], r[2], r[3], sum, lat, pulses);
      chk("rnd_sum", sum, exp_sum);
      chk("rnd_latency", lat, 13);
      chk("rnd_pulses", pulses, 3);
      w = $urandom_range(0, 3);
      repeat (w) tick();
      chk("rnd_hold", out_data, exp_sum);
      release_out();
      chk("rnd_idle", busy, 0);
    end

    // NUM=1: output one cycle after accept, no add issued
    b_in_valid = 1'b1; b_in_data = 16'h4200;
    chk("n1_in_ready", b_in_ready, 1);
    tick();
    b_in_valid = 1'b0;
    chk("n1_out_valid", b_out_valid, 1);
    chk("n1_out_data", b_out_data, 16'h4200);
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    chk("n1_idle", b_busy, 0);
    chk("n1_out_valid_drop", b_out_valid, 0);

    // hung adder: watchdog fires after 8 WAIT cycles
    hang = 1'b1;
    in_valid = 1'b1; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    in_valid = 1'b0;
    chk("hang_issue", add_valid, 1);
    n = 0; saw = 1'b0;
    while (busy && n < 50) begin
      if (out_valid) saw = 1'b1;
      n++;
      tick();
    end
    chk("hang_wait_cycles", n, 8);
    chk("hang_err", err, 1);
    chk("hang_busy", busy, 0);
    chk("hang_no_out_valid", saw, 0);
    chk("hang_acc_discard", out_data, 0);
    hang = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("hang_err_clr", err, 0);

    // spurious result in IDLE, including set-wins-over-clear
    send_frame(16'h1234, 16'h0001, 16'h0002, 16'h0003, sum, lat, pulses);
    chk("pre_spur_sum", sum, 16'h123A);
    release_out();
    saved = 16'h123A;
    spur = 1'b1; spur_data = 16'hBEEF;
    tick();
    spur = 1'b0;
    chk("spur_err", err, 1);
    chk("spur_acc_kept", out_data, saved);
    chk("spur_busy", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("spur_err_clr", err, 0);
    spur = 1'b1; err_clr = 1'b1;
    tick();
    spur = 1'b0; err_clr = 1'b0;
    chk("set_wins_clr", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("set_wins_then_clr", err, 0);
    exp_sum = '0;
    for (int k = 0; k < 4; k++) begin
      r[k] = 16'($urandom);
      exp_sum = exp_sum + r[k];
    end
    send_frame(r[0], r[1], r[2], r[3], sum, lat, pulses);
    chk("post_spur_sum", sum, exp_sum);
    release_out();

    // reset in WAIT with the add still in flight in the adder
    in_valid = 1'b1; in_data = 16'h0100;
    tick();
    in_data = 16'h0200;
    tick();
    in_valid = 1'b0;
    chk("rw_issue", add_valid, 1);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("rw_in_ready", in_ready, 1);
    chk("rw_out_valid", out_valid, 0);
    chk("rw_out_data", out_data, 0);
    chk("rw_add_valid", add_valid, 0);
    chk("rw_add_i0", add_i0, 0);
    chk("rw_add_i1", add_i1, 0);
    chk("rw_busy", busy, 0);
    chk("rw_err", err, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_late_result_present", add_valid_out, 1);
    chk("rw_err_before_late", err, 0);
    tick();
    chk("rw_late_err", err, 1);
    chk("rw_no_partial", out_valid, 0);
    chk("rw_idle", busy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_sum = '0;
    for (int k = 0; k < 4; k++) begin
      r[k] = 16'($urandom);
      exp_sum = exp_sum + r[k];
    end
    send_frame(r[0], r[1], r[2], r[3], sum, lat, pulses);
    chk("post_reset_sum", sum, exp_sum);
    chk("post_reset_latency", lat, 13);
    release_out();

    chk("no_back_to_back_issue", viol, 0);
    chk("n1_no_issue", b_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Time-multiplexed reduction sequencer. Sums NUM operands per frame using one shared external 2-input adder (the bits16/float16 2-input adder with a valid/valid_out interface) instead of a tree of NUM-1 adders.
- Accepts operands on a valid/ready stream, issues one add at a time, and accumulates the result.
- Presents the frame sum on a valid/ready output.
- Sits between the operand source and the adder instance, which the parent instantiates and connects.

Parameters:
- BITS, 16, data width of operands, accumulator and adder ports.
- NUM, 4, operands per frame; legal range 1..255.
- TIMEOUT, 64, maximum cycles in WAIT before the adder is declared hung; must be at least 2.

Ports:
- clk  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand valid
- in_ready  output  1  operand accepted when in_valid & in_ready
- in_data  input  BITS  operand
- out_valid  output  1  frame sum valid
- out_ready  input  1  sum consumed when out_valid & out_ready
- out_data  output  BITS  frame sum
- add_valid  output  1  issue strobe to adder (valid)
- add_i0  output  BITS  adder operand 0 (accumulator)
- add_i1  output  BITS  adder operand 1 (new operand)
- add_o  input  BITS  adder result
- add_valid_out  input  1  adder result strobe
- busy  output  1  frame in progress (state != IDLE)
- err  output  1  sticky error flag
- err_clr  input  1  synchronous clear of err

Behaviour:
- Clocking and reset: single clock clk. Reset is asynchronous and active-low on resetn.
- Reset values: state=IDLE, acc=0, cnt=0, wdog=0, add_valid=0, add_i0=0, add_i1=0, out_valid=0, err=0.
  - in_ready is decoded from state, so it reads 1 in IDLE/COLLECT, including during reset.
  - out_data=acc, so it reads 0 during reset.
- States: IDLE, COLLECT, WAIT, DONE.
- IDLE: in_ready=1.
  - On accept: acc<=in_data, cnt<=1.
  - Next state is DONE if NUM==1, else COLLECT.
- COLLECT: in_ready=1.
  - On accept at cycle T: add_i0<=acc, add_i1<=in_data, add_valid=1 during cycle T+1 only; go to WAIT.
- WAIT: in_ready=0; wdog counts cycles.
  - On add_valid_out: acc<=add_o, cnt<=cnt+1, wdog<=0.
  - Next state is DONE if cnt+1==NUM, else COLLECT.
  - The next operand can be accepted no earlier than the cycle after add_valid_out.
- DONE: out_valid=1, out_data=acc, held stable until out_ready.
  - On handshake: go to IDLE, out_valid=0 next cycle.
  - No back-to-back bypass: the next frame's first operand is accepted no earlier than the following cycle.
- Per-operand cost: 1 accept cycle + 1 issue cycle + adder latency L.
  - Frame latency from first accept to out_valid = 1 + (NUM-1)*(L+2) cycles.
- Arithmetic: this block does no arithmetic; it only sequences the external adder. Width BITS throughout, no truncation in this block.
- Watchdog: if wdog reaches TIMEOUT in WAIT, then:
  - err<=1;
  - the frame is discarded (acc<=0, cnt<=0);
  - go to IDLE, no out_valid;
  - a late add_valid_out arriving after this is treated as spurious.
- Spurious result: add_valid_out in any state other than WAIT sets err<=1, is otherwise ignored, and acc is unchanged.
- err and err_clr:
  - err is sticky and cleared only by err_clr or reset.
  - If err_clr and a set event occur in the same cycle, set wins.
- Reset mid-frame: all state is discarded immediately. No partial sum is emitted after release.
- in_valid with in_ready=0: no effect; the operand stays pending at the source.
- Verification properties:
  - add_valid is never high on two consecutive cycles.
  - At most one add is outstanding at any time.

Decomposition:
- Shared package adder_pkg holds:
  - the state enum type adder_seq_state_t;
  - the default BITS;
  - the float16 constants used by benches (0x3C00, 0x0000).
- The watchdog counter is a natural sub-module: adder_wdog (count, clear, timeout pulse), reusable by other adder controllers.
- The adder itself is not instantiated here; the parent wires it.

Test Plan:
- NUM=4, adder model L=2, operands 0x3C00, 0x4000, 0x4200, 0x4400 (1, 2, 3, 4) with in_valid held -> out_valid at cycle 1+3*4=13 after first accept, out_data=0x4900 (10.0); exactly 3 add_valid pulses.
- NUM=1, operand 0x4200 -> out_valid one cycle after accept, out_data=0x4200, zero add_valid pulses.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0; release -> IDLE, next frame sums correctly.
- Hung adder: suppress add_valid_out, TIMEOUT=8 -> err=1 after 8 WAIT cycles, state IDLE, no out_valid; err_clr pulse -> err=0.
- Spurious add_valid_out in IDLE -> err=1, acc unchanged; next frame result correct.
- Assert resetn low mid-WAIT, then release -> all outputs at reset values; a late add_valid_out in IDLE sets err; a new frame completes with the correct sum.
